// File: rtl/pa_ahbl_mst_if.sv
// AHB-Lite master port: converts BMU request/grant/complete handshakes into
// pipelined AHB-Lite address and data phases, with error and access-deny handling.
module pa_ahbl_mst_if #(
    parameter int unsigned DENY_LAT = 1
) (
    input  logic        ahbl_clk,
    input  logic        cpurst,
    input  logic        bmu_ahbl_xx_req,
    input  logic        bmu_ahbl_xx_req_dp,
    input  logic        bmu_ahbl_xx_acc_deny,
    input  logic [31:0] bmu_ahbl_xx_addr,
    input  logic [2:0]  bmu_ahbl_xx_burst,
    input  logic [3:0]  bmu_ahbl_xx_prot,
    input  logic        bmu_ahbl_xx_seq,
    input  logic [1:0]  bmu_ahbl_xx_size,
    input  logic [31:0] bmu_ahbl_xx_wdata,
    input  logic        bmu_ahbl_xx_write,
    output logic        ahbl_bmu_xx_grnt,
    output logic        ahbl_bmu_xx_trans_cmplt,
    output logic        ahbl_bmu_xx_acc_err,
    output logic [31:0] ahbl_bmu_xx_data,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp,
    output logic        ahbl_clk_en,
    output logic [1:0]  ahbl_dbginfo
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        ERR  = 2'b10,
        DENY = 2'b11
    } state_t;

    state_t      state, state_nxt;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [1:0]  cnt_q, cnt_nxt;

    logic addr_slot, addr_ok, drive, xfer_grnt, deny_grnt;
    logic cmplt, err;

    always_ff @(posedge ahbl_clk) begin
        if (cpurst) begin
            state   <= IDLE;
            write_q <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            if (xfer_grnt) begin
                write_q <= bmu_ahbl_xx_write;
                wdata_q <= bmu_ahbl_xx_wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        cmplt     = 1'b0;
        err       = 1'b0;

        // An address phase may be presented in IDLE or in a healthy data phase.
        addr_slot = (state == IDLE) | ((state == DATA) & ~hresp);
        addr_ok   = hready & addr_slot;
        drive     = bmu_ahbl_xx_req & ~bmu_ahbl_xx_acc_deny & addr_slot;
        xfer_grnt = bmu_ahbl_xx_req & ~bmu_ahbl_xx_acc_deny & addr_ok;
        deny_grnt = bmu_ahbl_xx_req & bmu_ahbl_xx_acc_deny & hready & (state == IDLE);

        case (state)
            IDLE: begin
                if (xfer_grnt) begin
                    state_nxt = DATA;
                end else if (deny_grnt) begin
                    state_nxt = DENY;
                    cnt_nxt   = 2'(DENY_LAT - 1);
                end
            end
            DATA: begin
                if (hresp) begin
                    state_nxt = ERR;
                end else if (hready) begin
                    cmplt     = 1'b1;
                    state_nxt = xfer_grnt ? DATA : IDLE;
                end
            end
            ERR: begin
                // Second error cycle; a slave that never raises hready keeps us here.
                if (hready) begin
                    cmplt     = 1'b1;
                    err       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DENY: begin
                if (cnt_q == 2'd0) begin
                    cmplt     = 1'b1;
                    err       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt_q - 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ahbl_bmu_xx_grnt        = ~cpurst & (xfer_grnt | deny_grnt);
        ahbl_bmu_xx_trans_cmplt = ~cpurst & cmplt;
        ahbl_bmu_xx_acc_err     = ~cpurst & cmplt & err;
        ahbl_bmu_xx_data        = (~cpurst & cmplt & ~err & ~write_q) ? hrdata : '0;
        htrans = '0;
        haddr  = '0;
        hwrite = 1'b0;
        hsize  = '0;
        hburst = '0;
        hprot  = '0;
        if (drive & ~cpurst) begin
            htrans = {1'b1, bmu_ahbl_xx_seq};
            haddr  = bmu_ahbl_xx_addr;
            hwrite = bmu_ahbl_xx_write;
            hsize  = {1'b0, bmu_ahbl_xx_size};
            hburst = bmu_ahbl_xx_burst;
            hprot  = bmu_ahbl_xx_prot;
        end
        hwdata       = wdata_q;
        ahbl_clk_en  = ~cpurst & (bmu_ahbl_xx_req_dp | (state != IDLE));
        ahbl_dbginfo = state;
    end

endmodule

// File: tb/tb_pa_ahbl_mst_if.sv
// Directed bench for pa_ahbl_mst_if with hand-computed expectations (DENY_LAT=2).
module tb_pa_ahbl_mst_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, req_dp, deny, seq, write;
    logic [31:0] addr, wdata;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [1:0]  size;
    logic        grnt, cmplt, acc_err;
    logic [31:0] data, haddr, hwdata, hrdata;
    logic [1:0]  htrans, dbg;
    logic        hwrite, hready, hresp, clk_en;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    pa_ahbl_mst_if #(.DENY_LAT(2)) dut (
        .ahbl_clk(clk), .cpurst(rst),
        .bmu_ahbl_xx_req(req), .bmu_ahbl_xx_req_dp(req_dp), .bmu_ahbl_xx_acc_deny(deny),
        .bmu_ahbl_xx_addr(addr), .bmu_ahbl_xx_burst(burst), .bmu_ahbl_xx_prot(prot),
        .bmu_ahbl_xx_seq(seq), .bmu_ahbl_xx_size(size), .bmu_ahbl_xx_wdata(wdata),
        .bmu_ahbl_xx_write(write),
        .ahbl_bmu_xx_grnt(grnt), .ahbl_bmu_xx_trans_cmplt(cmplt),
        .ahbl_bmu_xx_acc_err(acc_err), .ahbl_bmu_xx_data(data),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .ahbl_clk_en(clk_en), .ahbl_dbginfo(dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic r, input logic d, input logic [31:0] a,
                           input logic w, input logic s, input logic [31:0] wd);
        req = r; deny = d; addr = a; write = w; seq = s; wdata = wd;
    endtask

    // advance to the next cycle; checks are made mid-cycle at #4 after this returns
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_dp = 1'b0; burst = '0; prot = '0; size = 2'd2;
        hrdata = '0; hready = 1'b1; hresp = 1'b0;
        set_req(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        next_cyc(); next_cyc(); #4;
        check("rst_state", 32'(dbg), 32'd0);
        check("rst_htrans", 32'(htrans), 32'd0);
        check("rst_cmplt", 32'(cmplt), 32'd0);
        rst = 1'b0;

        // single read, zero wait states
        next_cyc();
        set_req(1'b1, 1'b0, 32'h2000_0010, 1'b0, 1'b0, '0);
        hrdata = 32'hA5A5_5A5A;
        #4;
        check("rd_grnt", 32'(grnt), 32'd1);
        check("rd_htrans", 32'(htrans), 32'd2);
        check("rd_haddr", haddr, 32'h2000_0010);
        check("rd_hsize", 32'(hsize), 32'd2);
        check("rd_cmplt0", 32'(cmplt), 32'd0);
        next_cyc();
        set_req(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        #4;
        check("rd_cmplt", 32'(cmplt), 32'd1);
        check("rd_data", data, 32'hA5A5_5A5A);
        check("rd_err", 32'(acc_err), 32'd0);
        check("rd_htrans_idle", 32'(htrans), 32'd0);
        next_cyc(); #4;
        check("rd_back_idle", 32'(dbg), 32'd0);

        // two pipelined writes
        next_cyc();
        burst = 3'd1; prot = 4'd3;
        set_req(1'b1, 1'b0, 32'h3000_0000, 1'b1, 1'b0, 32'h1111_1111);
        #4;
        check("wr0_grnt", 32'(grnt), 32'd1);
        check("wr0_htrans", 32'(htrans), 32'd2);
        check("wr0_hwrite", 32'(hwrite), 32'd1);
        check("wr0_hburst", 32'(hburst), 32'd1);
        check("wr0_hprot", 32'(hprot), 32'd3);
        next_cyc();
        set_req(1'b1, 1'b0, 32'h3000_0004, 1'b1, 1'b1, 32'h2222_2222);
        #4;
        check("wr1_grnt", 32'(grnt), 32'd1);
        check("wr1_htrans", 32'(htrans), 32'd3);
        check("wr1_haddr", haddr, 32'h3000_0004);
        check("wr0_hwdata", hwdata, 32'h1111_1111);
        check("wr0_cmplt", 32'(cmplt), 32'd1);
        check("wr0_data", data, 32'd0);
        next_cyc();
        set_req(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        burst = '0; prot = '0;
        #4;
        check("wr1_hwdata", hwdata, 32'h2222_2222);
        check("wr1_cmplt", 32'(cmplt), 32'd1);
        check("wr1_htrans_idle", 32'(htrans), 32'd0);

        // read with 3 wait states, next request pending
        next_cyc();
        set_req(1'b1, 1'b0, 32'h0000_0040, 1'b0, 1'b0, '0);
        #4;
        check("ws_grnt", 32'(grnt), 32'd1);
        next_cyc();
        set_req(1'b1, 1'b0, 32'h0000_0044, 1'b0, 1'b0, '0);
        hready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #4;
            check("ws_nogrnt", 32'(grnt), 32'd0);
            check("ws_nocmplt", 32'(cmplt), 32'd0);
            check("ws_htrans_held", 32'(htrans), 32'd2);
            check("ws_clk_en", 32'(clk_en), 32'd1);
            next_cyc();
        end
        set_req(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        hready = 1'b1; hrdata = 32'h1234_5678;
        #4;
        check("ws_cmplt", 32'(cmplt), 32'd1);
        check("ws_data", data, 32'h1234_5678);

        // two-cycle error response with a request pending
        next_cyc();
        set_req(1'b1, 1'b0, 32'h0000_0080, 1'b0, 1'b0, '0);
        #4;
        check("er_grnt", 32'(grnt), 32'd1);
        next_cyc();
        set_req(1'b1, 1'b0, 32'h0000_0084, 1'b0, 1'b0, '0);
        hresp = 1'b1; hready = 1'b0;
        #4;
        check("er1_htrans", 32'(htrans), 32'd0);
        check("er1_grnt", 32'(grnt), 32'd0);
        check("er1_cmplt", 32'(cmplt), 32'd0);
        next_cyc();
        hready = 1'b1;
        #4;
        check("er2_state", 32'(dbg), 32'd2);
        check("er2_cmplt", 32'(cmplt), 32'd1);
        check("er2_err", 32'(acc_err), 32'd1);
        check("er2_grnt", 32'(grnt), 32'd0);
        check("er2_htrans", 32'(htrans), 32'd0);
        check("er2_data", data, 32'd0);
        next_cyc();
        hresp = 1'b0;
        set_req(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        #4;
        check("er_back_idle", 32'(dbg), 32'd0);

        // access deny, DENY_LAT=2
        next_cyc();
        set_req(1'b1, 1'b1, 32'h5000_0000, 1'b0, 1'b0, '0);
        #4;
        check("dn_grnt", 32'(grnt), 32'd1);
        check("dn_htrans", 32'(htrans), 32'd0);
        next_cyc();
        set_req(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        #4;
        check("dn1_state", 32'(dbg), 32'd3);
        check("dn1_cmplt", 32'(cmplt), 32'd0);
        next_cyc(); #4;
        check("dn2_cmplt", 32'(cmplt), 32'd1);
        check("dn2_err", 32'(acc_err), 32'd1);
        next_cyc(); #4;
        check("dn3_cmplt", 32'(cmplt), 32'd0);
        check("dn3_state", 32'(dbg), 32'd0);

        // reset mid data phase
        next_cyc();
        set_req(1'b1, 1'b0, 32'h6000_0000, 1'b1, 1'b0, 32'hDEAD_BEEF);
        #4;
        check("rs_grnt", 32'(grnt), 32'd1);
        next_cyc();
        set_req(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        hready = 1'b0; rst = 1'b1;
        #4;
        check("rs_during_cmplt", 32'(cmplt), 32'd0);
        next_cyc();
        rst = 1'b0;
        #4;
        check("rs_state", 32'(dbg), 32'd0);
        check("rs_cmplt", 32'(cmplt), 32'd0);
        check("rs_htrans", 32'(htrans), 32'd0);
        check("rs_hwdata", hwdata, 32'd0);
        check("rs_clk_en", 32'(clk_en), 32'd0);
        check("rs_grnt0", 32'(grnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
